// File: rtl/layer_mux_ctrl_if.sv
// layer_mux_ctrl_if: video timing, layer inputs, update handshake and composited pixel bundle
//   master: timing generator, layer sources and game logic
//           drives rgb_hs/vs/de, rgb_x/y, lyr_hit, lyr_color, lyr_en, bg_color, upd_ack
//   slave : compositor / update controller
//           drives upd_req, upd_miss, frame_cnt, pix_hs/vs/de, pix_color
interface layer_mux_ctrl_if #(
    parameter int LAYERS  = 4,
    parameter int COLOR_W = 16
);
    logic                      rgb_hs;
    logic                      rgb_vs;
    logic                      rgb_de;
    logic [11:0]               rgb_x;
    logic [11:0]               rgb_y;
    logic [LAYERS-1:0]         lyr_hit;
    logic [LAYERS*COLOR_W-1:0] lyr_color;
    logic [LAYERS-1:0]         lyr_en;
    logic [COLOR_W-1:0]        bg_color;
    logic                      upd_ack;
    logic                      upd_req;
    logic                      upd_miss;
    logic [15:0]               frame_cnt;
    logic                      pix_hs;
    logic                      pix_vs;
    logic                      pix_de;
    logic [COLOR_W-1:0]        pix_color;

    modport master (
        output rgb_hs, rgb_vs, rgb_de, rgb_x, rgb_y, lyr_hit, lyr_color, lyr_en, bg_color, upd_ack,
        input  upd_req, upd_miss, frame_cnt, pix_hs, pix_vs, pix_de, pix_color
    );

    modport slave (
        input  rgb_hs, rgb_vs, rgb_de, rgb_x, rgb_y, lyr_hit, lyr_color, lyr_en, bg_color, upd_ack,
        output upd_req, upd_miss, frame_cnt, pix_hs, pix_vs, pix_de, pix_color
    );
endinterface

// File: rtl/layer_mux_ctrl.sv
// layer_mux_ctrl: fixed-priority layer compositor with per-frame game-state update handshake
//   rgb_clk : pixel clock
//   rgb_rst : asynchronous active-high reset
//   bus     : layer_mux_ctrl_if.slave -- timing/layer inputs in, composited pixel and
//             update handshake (upd_req/upd_ack, upd_miss, frame_cnt) out
module layer_mux_ctrl #(
    parameter int          LAYERS      = 4,
    parameter int          COLOR_W     = 16,
    parameter logic [15:0] UPD_TIMEOUT = 16'd4000,
    parameter logic        VS_POL      = 1'b0
) (
    input logic             rgb_clk,
    input logic             rgb_rst,
    layer_mux_ctrl_if.slave bus
);
    typedef enum logic [1:0] {S_ACTIVE, S_REQ, S_DONE} state_t;

    state_t             state_q, state_d;
    logic               vs_prev_q;
    logic [LAYERS-1:0]  en_q, en_d;
    logic [15:0]        timer_q, timer_d;
    logic [15:0]        frame_cnt_q, frame_cnt_d;
    logic               upd_req_q, upd_req_d;
    logic               upd_miss_q, upd_miss_d;
    logic [2:0]         tim_q, tim_d;
    logic [COLOR_W-1:0] pix_color_q, pix_color_d;
    logic               frame_start;
    logic               timeout;

    // Frame starts on the edge into the active vsync level.
    assign frame_start = (bus.rgb_vs == VS_POL) && (vs_prev_q != VS_POL);
    assign timeout     = timer_q == UPD_TIMEOUT - 16'd1;

    always_comb begin
        // Walk from highest to lowest index so the lowest-index hit is the one left standing.
        pix_color_d = bus.bg_color;
        for (int i = LAYERS - 1; i >= 0; i--)
            if (bus.lyr_hit[i] && en_q[i]) pix_color_d = bus.lyr_color[i*COLOR_W +: COLOR_W];
        if (!bus.rgb_de) pix_color_d = '0;
        tim_d = {bus.rgb_hs, bus.rgb_vs, bus.rgb_de};
        en_d  = frame_start ? bus.lyr_en : en_q;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_ACTIVE: if (frame_start) state_d = S_REQ;
            S_REQ:    if (bus.upd_ack || timeout) state_d = S_DONE;
            S_DONE:   if (bus.rgb_de) state_d = S_ACTIVE;
            default:  state_d = S_ACTIVE;
        endcase
    end

    // Ack has priority over timeout, so a miss is only flagged without ack.
    always_comb begin
        upd_req_d   = state_d == S_REQ;
        upd_miss_d  = (state_q == S_REQ) && !bus.upd_ack && timeout;
        frame_cnt_d = frame_cnt_q + 16'((state_q == S_REQ) && bus.upd_ack);
        timer_d     = (state_q == S_REQ) ? timer_q + 16'd1 : 16'd0;
    end

    always_ff @(posedge rgb_clk or posedge rgb_rst) begin
        if (rgb_rst) state_q <= S_ACTIVE;
        else         state_q <= state_d;
    end

    always_ff @(posedge rgb_clk or posedge rgb_rst) begin
        if (rgb_rst) begin
            vs_prev_q   <= ~VS_POL;
            en_q        <= '0;
            timer_q     <= '0;
            frame_cnt_q <= '0;
            upd_req_q   <= 1'b0;
            upd_miss_q  <= 1'b0;
            tim_q       <= '0;
            pix_color_q <= '0;
        end else begin
            vs_prev_q   <= bus.rgb_vs;
            en_q        <= en_d;
            timer_q     <= timer_d;
            frame_cnt_q <= frame_cnt_d;
            upd_req_q   <= upd_req_d;
            upd_miss_q  <= upd_miss_d;
            tim_q       <= tim_d;
            pix_color_q <= pix_color_d;
        end
    end

    assign bus.upd_req   = upd_req_q;
    assign bus.upd_miss  = upd_miss_q;
    assign bus.frame_cnt = frame_cnt_q;
    assign bus.pix_hs    = tim_q[2];
    assign bus.pix_vs    = tim_q[1];
    assign bus.pix_de    = tim_q[0];
    assign bus.pix_color = pix_color_q;
endmodule

// File: tb/tb_layer_mux_ctrl.sv
// tb_layer_mux_ctrl: randomized bench against a behavioural compositor/handshake model
module tb_layer_mux_ctrl;
    localparam int          LAYERS = 4;
    localparam int          CW     = 16;
    localparam logic [15:0] TO     = 16'd4000;
    localparam logic        VS_POL = 1'b0;
    localparam int          H_TOT = 40, H_ACT = 32, V_TOT = 12, V_ACT = 8, V_SYNC = 9;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;

    layer_mux_ctrl_if #(.LAYERS(LAYERS), .COLOR_W(CW)) bus ();

    layer_mux_ctrl #(.LAYERS(LAYERS), .COLOR_W(CW), .UPD_TIMEOUT(TO), .VS_POL(VS_POL)) dut (
        .rgb_clk(clk),
        .rgb_rst(rst),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [CW-1:0] top_color(input logic [LAYERS-1:0] hit, input logic [LAYERS-1:0] en,
                                                input logic [LAYERS*CW-1:0] col, input logic [CW-1:0] bg);
        for (int i = 0; i < LAYERS; i++)
            if (hit[i] && en[i]) return col[i*CW +: CW];
        return bg;
    endfunction

    // Behavioural model: a pending-handshake flag with an elapsed-cycle count.
    logic              m_prev;
    logic              m_fs;
    logic [LAYERS-1:0] m_en;
    bit                m_wait, m_hold;
    int                m_elapsed;
    logic [15:0]       m_cnt;
    logic              m_req, m_miss;
    logic [CW-1:0]     m_pix;
    logic [2:0]        m_tim;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_prev = ~VS_POL; m_en = '0; m_wait = 0; m_hold = 0; m_elapsed = 0;
            m_cnt = '0; m_req = 0; m_miss = 0; m_pix = '0; m_tim = '0;
        end else begin
            m_fs   = (bus.rgb_vs == VS_POL) && (m_prev != VS_POL);
            m_prev = bus.rgb_vs;
            m_tim  = {bus.rgb_hs, bus.rgb_vs, bus.rgb_de};
            m_pix  = bus.rgb_de ? top_color(bus.lyr_hit, m_en, bus.lyr_color, bus.bg_color) : '0;
            m_miss = 0;
            if (m_wait) begin
                m_elapsed++;
                if (bus.upd_ack) begin
                    m_cnt++; m_wait = 0; m_hold = 1;
                end else if (m_elapsed == TO) begin
                    m_miss = 1; m_wait = 0; m_hold = 1;
                end
            end else if (m_hold) m_hold = !bus.rgb_de;
            else if (m_fs) begin
                m_wait = 1; m_elapsed = 0;
            end
            m_req = m_wait;
            if (m_fs) m_en = bus.lyr_en;
        end
    end

    int          hc = 0, vc = 0;
    int          mode = 0, run = 0, ends = 0, misses = 0, exp_run = 0, dir_fs = 0;
    bit          dir = 0, dir_chk = 0;
    logic [3:0]  loaded_en = 4'hF;
    logic [15:0] dir_want = '0;

    task automatic drive();
        bus.rgb_de    = hc < H_ACT && vc < V_ACT;
        bus.rgb_hs    = !(hc >= 34 && hc < 37);
        bus.rgb_vs    = vc == V_SYNC ? VS_POL : ~VS_POL;
        bus.rgb_x     = 12'(hc);
        bus.rgb_y     = 12'(vc);
        bus.lyr_hit   = 4'($urandom);
        bus.lyr_color = {$urandom, $urandom};
        bus.bg_color  = 16'($urandom);
        if (mode == 3 && $urandom_range(0, 99) == 0) bus.lyr_en = 4'($urandom);
        if (dir) begin
            bus.lyr_hit = 4'b0110;
            bus.lyr_color[16 +: 16] = 16'hF800;
            bus.lyr_color[32 +: 16] = 16'h07E0;
            if (dir_fs == 1 && vc == 4 && hc == 0) bus.lyr_en = 4'b1101;
        end
        if (vc == V_SYNC && hc == 0) begin
            loaded_en = bus.lyr_en;
            if (dir) dir_fs++;
        end
        dir_chk  = dir && bus.rgb_de;
        dir_want = loaded_en[1] ? 16'hF800 : loaded_en[2] ? 16'h07E0 : bus.bg_color;
        case (mode)
            0:       bus.upd_ack = run == 101;
            1:       bus.upd_ack = 1'b0;
            2:       bus.upd_ack = run == 4000;
            default: bus.upd_ack = $urandom_range(0, 49) == 0;
        endcase
        hc++;
        if (hc == H_TOT) begin
            hc = 0;
            vc = (vc + 1) % V_TOT;
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        check("pix", bus.pix_color, m_pix);
        check("tim", {bus.pix_hs, bus.pix_vs, bus.pix_de}, m_tim);
        check("req", bus.upd_req, m_req);
        check("miss", bus.upd_miss, m_miss);
        check("cnt", bus.frame_cnt, m_cnt);
        if (dir_chk) check("prio", bus.pix_color, dir_want);
        if (bus.upd_miss) misses++;
        if (bus.upd_req) run++;
        else begin
            if (run != 0) begin
                ends++;
                if (exp_run != 0) check("req_len", run, exp_run);
            end
            run = 0;
        end
        drive();
    endtask

    task automatic phase(input int md, input int n_ends, input int want_len, input logic [3:0] en);
        mode = md; exp_run = want_len; ends = 0; misses = 0;
        bus.lyr_en = en;
        for (int g = 0; g < 9000 && ends < n_ends; g++) cycle();
        check("budget", ends, n_ends);
    endtask

    initial begin
        bus.rgb_hs = 1'b1; bus.rgb_vs = ~VS_POL; bus.rgb_de = 1'b0;
        bus.rgb_x = '0; bus.rgb_y = '0; bus.lyr_hit = '0; bus.lyr_color = '0;
        bus.lyr_en = 4'hF; bus.bg_color = '0; bus.upd_ack = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_req", bus.upd_req, 0);
        check("rst_miss", bus.upd_miss, 0);
        check("rst_cnt", bus.frame_cnt, 0);
        check("rst_pix", bus.pix_color, 0);
        check("rst_tim", {bus.pix_hs, bus.pix_vs, bus.pix_de}, 0);
        rst = 1'b0;
        drive();
        phase(0, 1, 101, 4'hF);
        check("cnt_first", bus.frame_cnt, 1);
        check("miss_first", misses, 0);
        phase(0, 2, 101, 4'hF);
        check("cnt_three", bus.frame_cnt, 3);
        dir = 1;
        phase(0, 3, 101, 4'hF);
        dir = 0;
        check("dir_frames", dir_fs, 3);
        check("cnt_dir", bus.frame_cnt, 6);
        phase(1, 1, 4000, 4'hF);
        check("miss_pulses", misses, 1);
        check("cnt_timeout", bus.frame_cnt, 6);
        phase(2, 1, 4000, 4'hF);
        check("miss_tie", misses, 0);
        check("cnt_tie", bus.frame_cnt, 7);
        phase(3, 4, 0, 4'hF);
        mode = 0; exp_run = 101;
        for (int g = 0; g < 2000 && run != 50; g++) cycle();
        check("run50", run, 50);
        rst = 1'b1;
        #1;
        check("abort_req", bus.upd_req, 0);
        check("abort_cnt", bus.frame_cnt, 0);
        run = 0;
        cycle();
        rst = 1'b0;
        phase(0, 1, 101, 4'hF);
        check("cnt_after_rst", bus.frame_cnt, 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/layer_mux_ctrl.md
LAYER_MUX_CTRL -- requirements
Module: layer_mux_ctrl

Interface
REQ-001 Parameter LAYERS, default 4: number of sprite/graphic layer requesters.
REQ-002 Parameter COLOR_W, default 16: RGB565 pixel width.
REQ-003 Parameter UPD_TIMEOUT, default 16'd4000: rgb_clk cycles allowed for a game-state update handshake.
REQ-004 Parameter VS_POL, default 1'b0: active level of rgb_vs.
REQ-005 rgb_clk  in  1  pixel clock; single clock domain.
REQ-006 rgb_rst  in  1  reset; asynchronous, active-high.
REQ-007 rgb_hs / rgb_vs / rgb_de  in  1 each  timing from the timing generator.
REQ-008 rgb_x / rgb_y  in  12 each  active-area pixel coordinates.
REQ-009 lyr_hit  in  LAYERS  per-layer "this layer covers the current pixel".
REQ-010 lyr_color  in  LAYERS*COLOR_W  per-layer color; layer i at bits [i*COLOR_W +: COLOR_W].
REQ-011 lyr_en  in  LAYERS  requested layer enables; sampled once per frame.
REQ-012 bg_color  in  COLOR_W  background color when no enabled layer hits.
REQ-013 upd_ack  in  1  game logic finished its per-frame update.
REQ-014 upd_req  out  1  request to game logic to update state (vertical blanking window).
REQ-015 upd_miss  out  1  one-cycle pulse: handshake timed out.
REQ-016 frame_cnt  out  16  count of successfully acknowledged updates.
REQ-017 pix_hs / pix_vs / pix_de  out  1 each  timing delayed to align with pix_color.
REQ-018 pix_color  out  COLOR_W  composited pixel.

Function
REQ-019 Pixel path SHALL have exactly 1 cycle latency: pix_hs/pix_vs/pix_de/pix_color register the inputs of the same cycle.
REQ-020 Compositing SHALL be fixed priority: lowest index i with lyr_hit[i] & en_q[i] wins; none -> bg_color.
REQ-021 pix_color SHALL be 0 whenever rgb_de was 0 in the sampled cycle.
REQ-022 Frame start event = cycle where rgb_vs transitions to VS_POL (registered previous value compared with current).
REQ-023 en_q SHALL load lyr_en on the frame start event only; it is constant for the remainder of the frame.
REQ-024 FSM states: S_ACTIVE, S_REQ, S_DONE.
REQ-025 S_ACTIVE -> S_REQ on frame start event; timer cleared to 0.
REQ-026 In S_REQ upd_req SHALL be 1 and timer increments each cycle.
REQ-027 S_REQ with upd_ack=1 -> S_DONE, frame_cnt+1 (wraps 16'hFFFF -> 0).
REQ-028 S_REQ with timer == UPD_TIMEOUT-1 and upd_ack=0 -> S_DONE, upd_miss=1 for that one cycle, frame_cnt unchanged.
REQ-029 ack and timeout in same cycle: ack wins, no upd_miss.
REQ-030 upd_req SHALL drop in the cycle after the transition out of S_REQ (registered output).
REQ-031 S_DONE -> S_ACTIVE on first cycle with rgb_de=1.
REQ-032 Frame start event in S_REQ or S_DONE SHALL be ignored for FSM (no restart) but en_q still loads.
REQ-033 upd_ack outside S_REQ SHALL be ignored.

Reset
REQ-034 On rgb_rst=1: FSM=S_ACTIVE, upd_req=0, upd_miss=0, frame_cnt=0, timer=0, en_q=0, pix_*=0, previous-vs register = ~VS_POL.
REQ-035 Reset mid-handshake SHALL abort immediately; first frame after release is handled normally.

Verification
REQ-036 640x480 timing, lyr_en=4'b1111, upd_ack 100 cycles after upd_req -> upd_req high 101 cycles, frame_cnt=1 after first frame, no upd_miss.
REQ-037 upd_ack never asserted -> upd_req high exactly 4000 cycles, one upd_miss pulse, frame_cnt stays 0.
REQ-038 lyr_hit=4'b0110, en=4'b1111, color1=16'hF800, color2=16'h07E0 -> pix_color=16'hF800 one cycle later; en=4'b1101 next frame -> 16'h07E0.
REQ-039 lyr_en changed mid-frame -> pix_color unchanged until next vs edge.
REQ-040 upd_ack asserted on the exact timeout cycle -> frame_cnt increments, upd_miss stays 0.
REQ-041 rgb_rst pulsed while upd_req=1 -> upd_req=0 and frame_cnt=0 immediately; next frame handshake completes.
